// File: rtl/extend_arbiter_if.sv
// Handshake bundle between two extend requesters, the shared result consumer
// and the arbiter; slave is the arbiter side, master the surrounding pipeline.
interface extend_arbiter_if #(
    parameter int CNT_W = 8
);
    logic             req0_valid;
    logic [15:0]      req0_a;
    logic             req0_sext;
    logic             req0_ready;
    logic             req1_valid;
    logic [15:0]      req1_a;
    logic             req1_sext;
    logic             req1_ready;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_b;
    logic             out_id;
    logic [CNT_W-1:0] txn_cnt;

    modport slave (
        input  req0_valid, req0_a, req0_sext,
        output req0_ready,
        input  req1_valid, req1_a, req1_sext,
        output req1_ready,
        input  out_ready,
        output out_valid, out_b, out_id, txn_cnt
    );

    modport master (
        output req0_valid, req0_a, req0_sext,
        input  req0_ready,
        output req1_valid, req1_a, req1_sext,
        input  req1_ready,
        output out_ready,
        input  out_valid, out_b, out_id, txn_cnt
    );
endinterface

// File: rtl/extend_arbiter.sv
// Round-robin arbiter sharing one 16->32 bit sign/zero extend unit between two
// requesters, with a single registered, ID-tagged output stage and accept counter.
module extend (
    input  logic [15:0] a,
    input  logic        sext,
    output logic [31:0] b
);
    assign b = {{16{sext & a[15]}}, a};
endmodule

module extend_arbiter #(
    parameter logic RR_INIT = 1'b0,
    parameter int   CNT_W   = 8
) (
    input logic              clk,
    input logic              rst,
    extend_arbiter_if.slave  bus
);
    logic             w_can_accept;
    logic             w_any;
    logic             w_win;
    logic             w_accept;
    logic [15:0]      w_a;
    logic             w_sext;
    logic [31:0]      w_ext;

    logic             r_out_valid;
    logic [31:0]      r_out_b;
    logic             r_out_id;
    logic             r_prio;
    logic [CNT_W-1:0] r_cnt;

    // Winner is only meaningful when w_any; with a single valid requester it is that one.
    always_comb begin
        w_can_accept = !r_out_valid || bus.out_ready;
        w_any        = bus.req0_valid || bus.req1_valid;
        w_win        = (bus.req0_valid && bus.req1_valid) ? r_prio : bus.req1_valid;
        w_a          = w_win ? bus.req1_a    : bus.req0_a;
        w_sext       = w_win ? bus.req1_sext : bus.req0_sext;
    end

    assign w_accept       = w_can_accept && w_any;
    assign bus.req0_ready = w_accept && !w_win;
    assign bus.req1_ready = w_accept &&  w_win;

    extend u_extend (
        .a    (w_a),
        .sext (w_sext),
        .b    (w_ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_b     <= '0;
            r_out_id    <= 1'b0;
            r_prio      <= RR_INIT;
            r_cnt       <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_b     <= w_ext;
            r_out_id    <= w_win;
            r_prio      <= ~w_win;
            r_cnt       <= r_cnt + CNT_W'(1);
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_b     = r_out_b;
    assign bus.out_id    = r_out_id;
    assign bus.txn_cnt   = r_cnt;
endmodule

// File: tb/tb_extend_arbiter.sv
// Randomised and directed checks of extend_arbiter against a cycle-level
// behavioural model of the arbitration and extension rules.
module tb_extend_arbiter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    extend_arbiter_if #(.CNT_W(8)) bif ();
    extend_arbiter_if #(.CNT_W(3)) bw ();

    extend_arbiter #(.RR_INIT(1'b0), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    extend_arbiter #(.RR_INIT(1'b1), .CNT_W(3)) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (bw.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural state of the main instance (RR_INIT=0, CNT_W=8)
    bit          m_ov;
    logic [31:0] m_b;
    bit          m_id;
    bit          m_prio;
    int          m_cnt;

    function automatic void model_reset();
        m_ov = 0; m_b = '0; m_id = 0; m_prio = 0; m_cnt = 0;
    endfunction

    function automatic int mgrant();
        if (!m_ov || bif.out_ready) begin
            if (bif.req0_valid && bif.req1_valid) return int'(m_prio);
            if (bif.req0_valid) return 0;
            if (bif.req1_valid) return 1;
        end
        return -1;
    endfunction

    function automatic logic [31:0] ext_ref(input logic [15:0] a, input bit s);
        int unsigned v;
        v = int'(a);
        if (s && v >= 32768) v = v + 32'hFFFF0000;
        return v;
    endfunction

    // Advance one clock and update the model from inputs present at the edge.
    task automatic tick();
        int          g;
        bit          ordy;
        logic [15:0] a;
        bit          s;
        g    = mgrant();
        ordy = bif.out_ready;
        a    = (g == 1) ? bif.req1_a    : bif.req0_a;
        s    = (g == 1) ? bif.req1_sext : bif.req0_sext;
        @(posedge clk);
        #1;
        if (g >= 0) begin
            m_b    = ext_ref(a, s);
            m_id   = (g == 1);
            m_ov   = 1;
            m_prio = (g == 0);
            m_cnt  = (m_cnt + 1) % 256;
        end else if (m_ov && ordy) begin
            m_ov = 0;
        end
    endtask

    task automatic idle_inputs();
        bif.req0_valid = 0; bif.req0_a = '0; bif.req0_sext = 0;
        bif.req1_valid = 0; bif.req1_a = '0; bif.req1_sext = 0;
        bif.out_ready  = 0;
        bw.req0_valid = 0; bw.req0_a = '0; bw.req0_sext = 0;
        bw.req1_valid = 0; bw.req1_a = '0; bw.req1_sext = 0;
        bw.out_ready  = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        n_checks++;
        if (bif.out_valid !== 1'b0 || bif.out_b !== 32'h0 || bif.out_id !== 1'b0 || bif.txn_cnt !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_values: valid=%b b=%h id=%b cnt=%0d required 0/0/0/0",
                     bif.out_valid, bif.out_b, bif.out_id, bif.txn_cnt);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (bif.req0_ready !== 1'b0 || bif.req1_ready !== 1'b0 || bif.out_valid !== 1'b0 ||
                bif.out_b !== 32'h0 || bif.txn_cnt !== 8'h0) begin
                n_fail++;
                $display("FAIL idle_after_reset: rdy=%b%b valid=%b b=%h cnt=%0d required 00/0/0/0",
                         bif.req1_ready, bif.req0_ready, bif.out_valid, bif.out_b, bif.txn_cnt);
            end
        end
    endtask

    task automatic test_single();
        logic [15:0] ta [4] = '{16'h8000, 16'h8000, 16'hFFFF, 16'h0000};
        bit          ts [4] = '{1, 0, 0, 1};
        bit          tr [4] = '{0, 1, 0, 0};
        bif.out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            if (tr[i]) begin
                bif.req1_valid = 1; bif.req1_a = ta[i]; bif.req1_sext = ts[i];
            end else begin
                bif.req0_valid = 1; bif.req0_a = ta[i]; bif.req0_sext = ts[i];
            end
            #1;
            n_checks++;
            if (bif.req0_ready !== (tr[i] == 0) || bif.req1_ready !== (tr[i] == 1)) begin
                n_fail++;
                $display("FAIL single_ready[%0d]: rdy=%b%b required req%0d only", i,
                         bif.req1_ready, bif.req0_ready, tr[i]);
            end
            tick();
            bif.req0_valid = 0; bif.req1_valid = 0;
            n_checks++;
            if (bif.out_valid !== 1'b1 || bif.out_b !== m_b || bif.out_id !== m_id) begin
                n_fail++;
                $display("FAIL single_result[%0d]: valid=%b b=%h id=%b required 1/%h/%b", i,
                         bif.out_valid, bif.out_b, bif.out_id, m_b, m_id);
            end
        end
        tick();
        n_checks++;
        if (bif.out_valid !== 1'b0 || bif.out_b !== m_b) begin
            n_fail++;
            $display("FAIL drain_hold: valid=%b b=%h required 0/%h", bif.out_valid, bif.out_b, m_b);
        end
    endtask

    task automatic test_contention();
        int  start;
        bit  expect_id;
        start     = m_cnt;
        expect_id = m_prio;
        bif.out_ready  = 1;
        bif.req0_valid = 1; bif.req0_a = 16'h1234; bif.req0_sext = 1;
        bif.req1_valid = 1; bif.req1_a = 16'hFFFF; bif.req1_sext = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (bif.out_id !== expect_id || bif.out_id !== m_id || bif.out_b !== m_b || bif.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL contention[%0d]: id=%b b=%h valid=%b required %b/%h/1", i,
                         bif.out_id, bif.out_b, bif.out_valid, expect_id, m_b);
            end
            expect_id = !expect_id;
        end
        n_checks++;
        if (int'(bif.txn_cnt) !== (start + 6) % 256) begin
            n_fail++;
            $display("FAIL contention_count: cnt=%0d required %0d", bif.txn_cnt, (start + 6) % 256);
        end
        bif.req0_valid = 0; bif.req1_valid = 0;
        tick();
    endtask

    task automatic test_backpressure();
        bif.out_ready  = 1;
        bif.req0_valid = 1; bif.req0_a = 16'h00AA; bif.req0_sext = 0;
        tick();
        bif.out_ready  = 0;
        bif.req0_a = 16'h1111;
        bif.req1_valid = 1; bif.req1_a = 16'h8001; bif.req1_sext = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (bif.req0_ready !== 1'b0 || bif.req1_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_ready[%0d]: rdy=%b%b required 00", i, bif.req1_ready, bif.req0_ready);
            end
            tick();
            n_checks++;
            if (bif.out_valid !== 1'b1 || bif.out_b !== 32'h000000AA || bif.out_id !== 1'b0 ||
                int'(bif.txn_cnt) !== m_cnt) begin
                n_fail++;
                $display("FAIL bp_frozen[%0d]: valid=%b b=%h id=%b cnt=%0d required 1/000000aa/0/%0d", i,
                         bif.out_valid, bif.out_b, bif.out_id, bif.txn_cnt, m_cnt);
            end
        end
        bif.out_ready = 1;
        #1;
        n_checks++;
        if (bif.req1_ready !== 1'b1 || bif.req0_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release_ready: rdy=%b%b required 10", bif.req1_ready, bif.req0_ready);
        end
        tick();
        n_checks++;
        if (bif.out_valid !== 1'b1 || bif.out_id !== 1'b1 || bif.out_b !== 32'hFFFF8001) begin
            n_fail++;
            $display("FAIL bp_refill: valid=%b id=%b b=%h required 1/1/ffff8001",
                     bif.out_valid, bif.out_id, bif.out_b);
        end
        bif.req0_valid = 0; bif.req1_valid = 0;
        tick();
    endtask

    task automatic test_random();
        int g;
        for (int i = 0; i < 300; i++) begin
            bif.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            g = mgrant();
            n_checks++;
            if (bif.req0_ready !== (g == 0) || bif.req1_ready !== (g == 1)) begin
                n_fail++;
                $display("FAIL rand_ready[%0d]: rdy=%b%b required %b%b", i,
                         bif.req1_ready, bif.req0_ready, g == 1, g == 0);
            end
            tick();
            n_checks++;
            if (bif.out_valid !== m_ov || bif.out_b !== m_b || bif.out_id !== m_id || int'(bif.txn_cnt) !== m_cnt) begin
                n_fail++;
                $display("FAIL rand_out[%0d]: valid=%b b=%h id=%b cnt=%0d required %b/%h/%b/%0d", i,
                         bif.out_valid, bif.out_b, bif.out_id, bif.txn_cnt, m_ov, m_b, m_id, m_cnt);
            end
            // A requester may only change its operand once it was accepted or idle
            if (g == 0 || !bif.req0_valid) begin
                bif.req0_valid = $urandom_range(0, 1); bif.req0_a = 16'($urandom); bif.req0_sext = $urandom_range(0, 1);
            end
            if (g == 1 || !bif.req1_valid) begin
                bif.req1_valid = $urandom_range(0, 1); bif.req1_a = 16'($urandom); bif.req1_sext = $urandom_range(0, 1);
            end
        end
        bif.req0_valid = 0; bif.req1_valid = 0; bif.out_ready = 1;
        tick();
    endtask

    task automatic test_wrap();
        int accepted;
        accepted = 0;
        bw.out_ready  = 1;
        bw.req0_valid = 1; bw.req0_a = 16'h0001; bw.req0_sext = 0;
        bw.req1_valid = 1; bw.req1_a = 16'h0002; bw.req1_sext = 0;
        #1;
        n_checks++;
        if (bw.req1_ready !== 1'b1 || bw.req0_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_rr_init: rdy=%b%b required 10", bw.req1_ready, bw.req0_ready);
        end
        tick();
        accepted++;
        bw.req1_valid = 0;
        n_checks++;
        if (bw.out_id !== 1'b1 || bw.out_b !== 32'h00000002) begin
            n_fail++;
            $display("FAIL wrap_first: id=%b b=%h required 1/00000002", bw.out_id, bw.out_b);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            accepted++;
        end
        n_checks++;
        if (int'(bw.txn_cnt) !== accepted % 8) begin
            n_fail++;
            $display("FAIL wrap_count: cnt=%0d required %0d", bw.txn_cnt, accepted % 8);
        end
        bw.req0_valid = 0;
        tick();
    endtask

    task automatic test_async_reset();
        bif.out_ready  = 0;
        bif.req0_valid = 1; bif.req0_a = 16'h4321; bif.req0_sext = 0;
        tick();
        bif.req0_valid = 0;
        n_checks++;
        if (bif.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_pending: valid=%b required 1", bif.out_valid);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (bif.out_valid !== 1'b0 || bif.txn_cnt !== 8'h0 || bif.out_b !== 32'h0) begin
            n_fail++;
            $display("FAIL arst_immediate: valid=%b cnt=%0d b=%h required 0/0/0",
                     bif.out_valid, bif.txn_cnt, bif.out_b);
        end
        #1 rst = 1'b0;
        model_reset();
        bif.out_ready  = 1;
        bif.req0_valid = 1; bif.req0_a = 16'h0F0F; bif.req0_sext = 1;
        bif.req1_valid = 1; bif.req1_a = 16'hF0F0; bif.req1_sext = 1;
        #1;
        n_checks++;
        if (bif.req0_ready !== 1'b1 || bif.req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_rr_init: rdy=%b%b required 01", bif.req1_ready, bif.req0_ready);
        end
        tick();
        n_checks++;
        if (bif.out_id !== 1'b0 || bif.out_b !== m_b || int'(bif.txn_cnt) !== m_cnt) begin
            n_fail++;
            $display("FAIL arst_first_grant: id=%b b=%h cnt=%0d required 0/%h/%0d",
                     bif.out_id, bif.out_b, bif.txn_cnt, m_b, m_cnt);
        end
        bif.req0_valid = 0; bif.req1_valid = 0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_random();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
